// File: rtl/shared_reg_write_arbiter_pkg.sv
// rtl/shared_reg_write_arbiter_pkg.sv - shared state encodings and clog2 helper
package shared_reg_write_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/shared_reg_write_arbiter_rr_priority_pick.sv
// rtl/shared_reg_write_arbiter_rr_priority_pick.sv - round-robin first-set-bit picker
module rr_priority_pick
    import shared_reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [clog2(NREQ)-1:0]   ptr,
    output logic                     found,
    output logic [clog2(NREQ)-1:0]   idx
);

    localparam int PW = clog2(NREQ);

    logic [2*NREQ-1:0] req_twice;
    logic [NREQ-1:0]   rotated;
    logic [PW:0]       ptr_ext;
    logic [PW-1:0]     offset;
    logic [PW:0]       sum;

    // Doubling the vector turns the rotation into a plain part-select.
    assign req_twice = {req, req};
    assign ptr_ext   = {1'b0, ptr};
    assign rotated   = req_twice[ptr_ext +: NREQ];

    always_comb begin
        found  = |req;
        offset = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = PW'(j);
            end
        end
        sum = ptr_ext + {1'b0, offset};
        if (sum >= (PW + 1)'(NREQ)) begin
            sum = sum - (PW + 1)'(NREQ);
        end
        idx = sum[PW-1:0];
    end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// rtl/shared_reg_write_arbiter.sv - round-robin req/ack arbiter for one shared register
module shared_reg_write_arbiter
    import shared_reg_write_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    input  logic                     set_req,
    output logic [NREQ-1:0]          ack,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     busy,
    output logic [WIDTH-1:0]         q
);

    localparam int PW = clog2(NREQ);

    logic [1:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic [WIDTH-1:0] wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_wdata
        assign wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
    end

    rr_priority_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '1;
            ack      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            state    <= ST_IDLE;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    q     <= wdata_arr[grant_id];
                    ack   <= {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    rr_ptr <= (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
            // Dominant set wins over a write landing in the same cycle.
            if (set_req) begin
                q <= '1;
            end
        end
    end

endmodule
